// File: rtl/clarvi_regfile_sequencer_pkg.sv
// clarvi_regfile_sequencer_pkg: shared register-part encoding and the zero register index
package clarvi_regfile_sequencer_pkg;
   typedef enum logic {PART_LO = 1'b0, PART_HI = 1'b1} part_t;
   localparam int unsigned ZERO_REG = 0;
endpackage

// File: rtl/clarvi_rf_write_splitter.sv
// clarvi_rf_write_splitter: turns one 64-bit writeback into a low-part then high-part write
module clarvi_rf_write_splitter
   import clarvi_regfile_sequencer_pkg::*;
#(
   parameter int HALF_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                clock_i,
   input  logic                reset_i,
   input  logic                wb_valid_i,
   output logic                wb_ready_o,
   input  logic [ADDR_W-1:0]   wb_rd_i,
   input  logic [2*HALF_W-1:0] wb_data_i,
   output logic                rf_write_part_o,
   output logic [ADDR_W-1:0]   rf_write_register_o,
   output logic [HALF_W-1:0]   rf_data_in_o,
   output logic                rf_write_enable_o,
   output logic                busy_o,
   output logic [ADDR_W-1:0]   pend_rd_o
);
   typedef enum logic {W_IDLE, W_HI} wr_state_t;
   wr_state_t           state_q, state_d;
   logic [ADDR_W-1:0]   rd_q, rd_d;
   logic [HALF_W-1:0]   hi_q, hi_d;
   logic                idle, accept;
   assign idle   = state_q == W_IDLE;
   assign accept = idle && wb_valid_i;
   // next state: an accepted writeback parks its index and upper half for the second cycle
   always_comb begin
      state_d = accept ? W_HI : W_IDLE;
      rd_d    = accept ? wb_rd_i : rd_q;
      hi_d    = accept ? wb_data_i[2*HALF_W-1:HALF_W] : hi_q;
   end
   // state and capture registers
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= W_IDLE;
         rd_q    <= '0;
         hi_q    <= '0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         hi_q    <= hi_d;
      end
   end
   assign wb_ready_o          = idle;
   assign rf_write_enable_o   = idle ? wb_valid_i : 1'b1;
   assign rf_write_part_o     = idle ? PART_LO : PART_HI;
   assign rf_write_register_o = idle ? wb_rd_i : rd_q;
   assign rf_data_in_o        = idle ? wb_data_i[HALF_W-1:0] : hi_q;
   assign busy_o              = !idle;
   assign pend_rd_o           = rd_q;
endmodule

// File: rtl/clarvi_regfile_sequencer.sv
// clarvi_regfile_sequencer: presents a two-part register file as whole 64-bit registers
module clarvi_regfile_sequencer
   import clarvi_regfile_sequencer_pkg::*;
#(
   parameter int HALF_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                clock_i,
   input  logic                reset_i,
   input  logic                rd_req_valid_i,
   output logic                rd_req_ready_o,
   input  logic [ADDR_W-1:0]   rd_rs1_i,
   input  logic [ADDR_W-1:0]   rd_rs2_i,
   output logic                rd_rsp_valid_o,
   input  logic                rd_rsp_ready_i,
   output logic [2*HALF_W-1:0] rd_op1_o,
   output logic [2*HALF_W-1:0] rd_op2_o,
   input  logic                wb_valid_i,
   output logic                wb_ready_o,
   input  logic [ADDR_W-1:0]   wb_rd_i,
   input  logic [2*HALF_W-1:0] wb_data_i,
   output logic                rf_fetch_part_o,
   output logic [ADDR_W-1:0]   rf_fetch_register_1_o,
   output logic [ADDR_W-1:0]   rf_fetch_register_2_o,
   input  logic [HALF_W-1:0]   rf_data_out_1_i,
   input  logic [HALF_W-1:0]   rf_data_out_2_i,
   output logic                rf_write_part_o,
   output logic [ADDR_W-1:0]   rf_write_register_o,
   output logic [HALF_W-1:0]   rf_data_in_o,
   output logic                rf_write_enable_o
);
   typedef enum logic [1:0] {R_IDLE, R_HI, R_RESP} rd_state_t;
   rd_state_t             state_q, state_d;
   logic [ADDR_W-1:0]     rs1_q, rs1_d, rs2_q, rs2_d;
   logic [2*HALF_W-1:0]   op1_q, op1_d, op2_q, op2_d;
   logic                  wr_busy, hazard, idle, accept;
   logic [ADDR_W-1:0]     wr_pend;
   clarvi_rf_write_splitter #(.HALF_W(HALF_W), .ADDR_W(ADDR_W)) u_wr (
      .clock_i             (clock_i),
      .reset_i             (reset_i),
      .wb_valid_i          (wb_valid_i),
      .wb_ready_o          (wb_ready_o),
      .wb_rd_i             (wb_rd_i),
      .wb_data_i           (wb_data_i),
      .rf_write_part_o     (rf_write_part_o),
      .rf_write_register_o (rf_write_register_o),
      .rf_data_in_o        (rf_data_in_o),
      .rf_write_enable_o   (rf_write_enable_o),
      .busy_o              (wr_busy),
      .pend_rd_o           (wr_pend)
   );
   // a register with only its low part rewritten must not be fetched until the high part lands
   assign hazard = wr_busy && wr_pend != ADDR_W'(ZERO_REG) &&
                   (wr_pend == rd_rs1_i || wr_pend == rd_rs2_i);
   assign idle   = state_q == R_IDLE;
   assign accept = idle && rd_req_valid_i && !hazard;
   // next state: low halves captured on accept, high halves in R_HI, then hold until taken
   always_comb begin
      state_d = idle ? (accept ? R_HI : R_IDLE) :
                (state_q == R_HI) ? R_RESP : (rd_rsp_ready_i ? R_IDLE : R_RESP);
      rs1_d   = accept ? rd_rs1_i : rs1_q;
      rs2_d   = accept ? rd_rs2_i : rs2_q;
      op1_d   = accept ? {op1_q[2*HALF_W-1:HALF_W], rf_data_out_1_i} :
                (state_q == R_HI) ? {rf_data_out_1_i, op1_q[HALF_W-1:0]} : op1_q;
      op2_d   = accept ? {op2_q[2*HALF_W-1:HALF_W], rf_data_out_2_i} :
                (state_q == R_HI) ? {rf_data_out_2_i, op2_q[HALF_W-1:0]} : op2_q;
   end
   // read FSM state, captured indices and assembled operands
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= R_IDLE;
         rs1_q   <= '0;
         rs2_q   <= '0;
         op1_q   <= '0;
         op2_q   <= '0;
      end else begin
         state_q <= state_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
      end
   end
   assign rd_req_ready_o        = idle && !hazard;
   assign rd_rsp_valid_o        = state_q == R_RESP;
   assign rd_op1_o              = op1_q;
   assign rd_op2_o              = op2_q;
   assign rf_fetch_part_o       = idle ? PART_LO : PART_HI;
   assign rf_fetch_register_1_o = idle ? rd_rs1_i : rs1_q;
   assign rf_fetch_register_2_o = idle ? rd_rs2_i : rs2_q;
endmodule

// File: tb/tb_clarvi_regfile_sequencer.sv
// tb_clarvi_regfile_sequencer: directed vectors against a behavioural two-part register file
module tb_clarvi_regfile_sequencer;
   localparam int H = 32;
   localparam int A = 5;
   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           rd_req_valid = 1'b0, rd_req_ready;
   logic [A-1:0]   rd_rs1 = '0, rd_rs2 = '0;
   logic           rd_rsp_valid, rd_rsp_ready = 1'b0;
   logic [2*H-1:0] rd_op1, rd_op2;
   logic           wb_valid = 1'b0, wb_ready;
   logic [A-1:0]   wb_rd = '0;
   logic [2*H-1:0] wb_data = '0;
   logic           rf_fetch_part, rf_write_part, rf_write_enable;
   logic [A-1:0]   rf_fetch_register_1, rf_fetch_register_2, rf_write_register;
   logic [H-1:0]   rf_data_out_1, rf_data_out_2, rf_data_in;
   logic [H-1:0]   lo_m [32];
   logic [H-1:0]   hi_m [32];
   int             total = 0;
   int             bad = 0;

   always #5 clk = ~clk;

   clarvi_regfile_sequencer #(.HALF_W(H), .ADDR_W(A)) dut (
      .clock_i               (clk),
      .reset_i               (rst),
      .rd_req_valid_i        (rd_req_valid),
      .rd_req_ready_o        (rd_req_ready),
      .rd_rs1_i              (rd_rs1),
      .rd_rs2_i              (rd_rs2),
      .rd_rsp_valid_o        (rd_rsp_valid),
      .rd_rsp_ready_i        (rd_rsp_ready),
      .rd_op1_o              (rd_op1),
      .rd_op2_o              (rd_op2),
      .wb_valid_i            (wb_valid),
      .wb_ready_o            (wb_ready),
      .wb_rd_i               (wb_rd),
      .wb_data_i             (wb_data),
      .rf_fetch_part_o       (rf_fetch_part),
      .rf_fetch_register_1_o (rf_fetch_register_1),
      .rf_fetch_register_2_o (rf_fetch_register_2),
      .rf_data_out_1_i       (rf_data_out_1),
      .rf_data_out_2_i       (rf_data_out_2),
      .rf_write_part_o       (rf_write_part),
      .rf_write_register_o   (rf_write_register),
      .rf_data_in_o          (rf_data_in),
      .rf_write_enable_o     (rf_write_enable)
   );

   // register file model: clocked part write, combinational part read, x0 reads as zero
   always @(posedge clk) begin
      if (rf_write_enable) begin
         if (rf_write_part) hi_m[rf_write_register] <= rf_data_in;
         else lo_m[rf_write_register] <= rf_data_in;
      end
   end
   assign rf_data_out_1 = (rf_fetch_register_1 == '0) ? '0 :
                          rf_fetch_part ? hi_m[rf_fetch_register_1] : lo_m[rf_fetch_register_1];
   assign rf_data_out_2 = (rf_fetch_register_2 == '0) ? '0 :
                          rf_fetch_part ? hi_m[rf_fetch_register_2] : lo_m[rf_fetch_register_2];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", nm, act, exp);
      end
   endtask

   task automatic do_write(input logic [A-1:0] r, input logic [63:0] d);
      @(negedge clk);
      wb_valid = 1'b1;
      wb_rd    = r;
      wb_data  = d;
      @(negedge clk);
      wb_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_read(input logic [A-1:0] s1, input logic [A-1:0] s2,
                          output logic [63:0] o1, output logic [63:0] o2, output int lat);
      int n;
      @(negedge clk);
      rd_req_valid = 1'b1;
      rd_rs1       = s1;
      rd_rs2       = s2;
      #1;
      n = 0;
      while (!rd_req_ready && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk1("req_accept", rd_req_ready, 1'b1);
      @(negedge clk);
      rd_req_valid = 1'b0;
      lat = 1;
      while (!rd_rsp_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      o1 = rd_op1;
      o2 = rd_op2;
      rd_rsp_ready = 1'b1;
      @(negedge clk);
      rd_rsp_ready = 1'b0;
   endtask

   typedef struct {
      bit             wr;
      logic [A-1:0]   wrd;
      logic [63:0]    wd;
      logic [A-1:0]   rs1;
      logic [A-1:0]   rs2;
      logic [63:0]    e1;
      logic [63:0]    e2;
   } vec_t;

   vec_t vecs [8];

   initial begin
      logic [63:0] o1, o2;
      int          lat;
      vecs[0] = '{1'b1, 5'd5,  64'h1122334455667788, 5'd5,  5'd0,  64'h1122334455667788, 64'h0};
      vecs[1] = '{1'b1, 5'd6,  64'hDEADBEEFCAFEF00D, 5'd6,  5'd5,  64'hDEADBEEFCAFEF00D, 64'h1122334455667788};
      vecs[2] = '{1'b1, 5'd0,  64'hFFFFFFFFFFFFFFFF, 5'd0,  5'd6,  64'h0, 64'hDEADBEEFCAFEF00D};
      vecs[3] = '{1'b1, 5'd31, 64'h8000000000000001, 5'd31, 5'd31, 64'h8000000000000001, 64'h8000000000000001};
      vecs[4] = '{1'b0, 5'd0,  64'h0,                5'd5,  5'd31, 64'h1122334455667788, 64'h8000000000000001};
      vecs[5] = '{1'b1, 5'd5,  64'h00000000FFFFFFFF, 5'd6,  5'd5,  64'hDEADBEEFCAFEF00D, 64'h00000000FFFFFFFF};
      vecs[6] = '{1'b1, 5'd9,  64'h0123456789ABCDEF, 5'd9,  5'd0,  64'h0123456789ABCDEF, 64'h0};
      vecs[7] = '{1'b1, 5'd3,  64'hAAAAAAAABBBBBBBB, 5'd3,  5'd0,  64'hAAAAAAAABBBBBBBB, 64'h0};

      repeat (2) @(negedge clk);
      chk1("rst_req_ready", rd_req_ready, 1'b1);
      chk1("rst_wb_ready", wb_ready, 1'b1);
      chk1("rst_rsp_valid", rd_rsp_valid, 1'b0);
      chk1("rst_wen", rf_write_enable, 1'b0);
      chk("rst_op1", rd_op1, 64'h0);
      chk("rst_op2", rd_op2, 64'h0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         if (vecs[i].wr) do_write(vecs[i].wrd, vecs[i].wd);
         do_read(vecs[i].rs1, vecs[i].rs2, o1, o2, lat);
         chk($sformatf("vec%0d_op1", i), o1, vecs[i].e1);
         chk($sformatf("vec%0d_op2", i), o2, vecs[i].e2);
         chk($sformatf("vec%0d_lat", i), 64'(lat), 64'd2);
      end

      // write x7 accepted, same-register read offered the next cycle is held off
      @(negedge clk);
      wb_valid = 1'b1;
      wb_rd    = 5'd7;
      wb_data  = 64'h7777777712345678;
      @(negedge clk);
      wb_valid     = 1'b0;
      rd_req_valid = 1'b1;
      rd_rs1       = 5'd0;
      rd_rs2       = 5'd7;
      #1;
      chk1("haz_blocked", rd_req_ready, 1'b0);
      @(negedge clk);
      #1;
      chk1("haz_released", rd_req_ready, 1'b1);
      @(negedge clk);
      rd_req_valid = 1'b0;
      @(negedge clk);
      chk1("haz_rsp_valid", rd_rsp_valid, 1'b1);
      chk("haz_op1", rd_op1, 64'h0);
      chk("haz_op2", rd_op2, 64'h7777777712345678);
      rd_rsp_ready = 1'b1;
      @(negedge clk);
      rd_rsp_ready = 1'b0;

      // simultaneous read and write of x9: read returns the old value, later read the new
      @(negedge clk);
      wb_valid     = 1'b1;
      wb_rd        = 5'd9;
      wb_data      = 64'hFEDCBA9876543210;
      rd_req_valid = 1'b1;
      rd_rs1       = 5'd9;
      rd_rs2       = 5'd0;
      #1;
      chk1("same_ready", rd_req_ready, 1'b1);
      @(negedge clk);
      wb_valid     = 1'b0;
      rd_req_valid = 1'b0;
      @(negedge clk);
      chk1("same_rsp_valid", rd_rsp_valid, 1'b1);
      chk("same_old_op1", rd_op1, 64'h0123456789ABCDEF);
      rd_rsp_ready = 1'b1;
      @(negedge clk);
      rd_rsp_ready = 1'b0;
      do_read(5'd9, 5'd0, o1, o2, lat);
      chk("same_new_op1", o1, 64'hFEDCBA9876543210);

      // response back-pressure: operands hold and no new request is taken
      @(negedge clk);
      rd_req_valid = 1'b1;
      rd_rs1       = 5'd5;
      rd_rs2       = 5'd6;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk1($sformatf("bp%0d_valid", i), rd_rsp_valid, 1'b1);
         chk1($sformatf("bp%0d_req_ready", i), rd_req_ready, 1'b0);
         chk($sformatf("bp%0d_op1", i), rd_op1, 64'h00000000FFFFFFFF);
         chk($sformatf("bp%0d_op2", i), rd_op2, 64'hDEADBEEFCAFEF00D);
         @(negedge clk);
      end
      rd_req_valid = 1'b0;
      rd_rsp_ready = 1'b1;
      @(negedge clk);
      rd_rsp_ready = 1'b0;

      // back-to-back writebacks with wb_valid held high
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         wb_valid = 1'b1;
         wb_rd    = (i < 2) ? 5'd10 : 5'd11;
         wb_data  = (i < 2) ? 64'h1010101020202020 : 64'h3030303040404040;
         #1;
         chk1($sformatf("b2b%0d_ready", i), wb_ready, 1'(i % 2 == 0));
         chk1($sformatf("b2b%0d_part", i), rf_write_part, 1'(i % 2));
         chk1($sformatf("b2b%0d_wen", i), rf_write_enable, 1'b1);
      end
      @(negedge clk);
      wb_valid = 1'b0;
      do_read(5'd10, 5'd11, o1, o2, lat);
      chk("b2b_x10", o1, 64'h1010101020202020);
      chk("b2b_x11", o2, 64'h3030303040404040);

      // reset while the write of x3 is in its high cycle and a read is in flight
      @(negedge clk);
      wb_valid     = 1'b1;
      wb_rd        = 5'd3;
      wb_data      = 64'hCCCCCCCCDDDDDDDD;
      rd_req_valid = 1'b1;
      rd_rs1       = 5'd5;
      rd_rs2       = 5'd6;
      @(negedge clk);
      wb_valid     = 1'b0;
      rd_req_valid = 1'b0;
      #1;
      chk1("mid_in_whi", wb_ready, 1'b0);
      rst = 1'b1;
      #1;
      chk1("mid_wb_ready", wb_ready, 1'b1);
      chk1("mid_wen", rf_write_enable, 1'b0);
      chk1("mid_rsp_valid", rd_rsp_valid, 1'b0);
      chk1("mid_req_ready", rd_req_ready, 1'b1);
      chk1("mid_fetch_part", rf_fetch_part, 1'b0);
      chk("mid_op1", rd_op1, 64'h0);
      chk("mid_op2", rd_op2, 64'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk1("post_rsp_valid", rd_rsp_valid, 1'b0);
      do_read(5'd3, 5'd0, o1, o2, lat);
      chk("torn_x3", o1, 64'hAAAAAAAADDDDDDDD);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
